// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared defaults and sizing helpers for pipe_adder
package pipe_adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SEG_W = 8;

    function automatic int nseg(int w, int s);
        return w / s;
    endfunction

    // Offset of stage k's pending-b slice in the packed triangular store;
    // stage j (j >= 1) keeps w - j*s bits of b still to be added.
    function automatic int tri_off(int w, int s, int k);
        int acc;
        acc = 0;
        for (int j = 1; j < k; j++) begin
            acc += w - j * s;
        end
        return acc;
    endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// rtl/adder_seg_stage.sv - registered SEG_W-bit add of one segment with carry in/out
module adder_seg_stage #(
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [SEG_W-1:0] a_seg,
    input  logic [SEG_W-1:0] b_seg,
    input  logic             c_in,
    output logic [SEG_W-1:0] s_seg,
    output logic             c_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg <= '0;
            c_out <= 1'b0;
        end else if (ld) begin
            {c_out, s_seg} <= {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, c_in};
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - segmented pipelined adder with valid/ready handshake (option: PIPE_ADDER_SUB_EN)
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEG_W = DEFAULT_SEG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSEG = nseg(WIDTH, SEG_W);
    localparam int BP_W = tri_off(WIDTH, SEG_W, NSEG);

    if (WIDTH < 1 || SEG_W < 1 || (WIDTH % SEG_W) != 0) begin : g_bad_cfg
        $fatal(1, "pipe_adder: WIDTH must be a nonzero multiple of SEG_W");
    end

    logic [NSEG:0]      rdy;
    logic [NSEG-1:0]    v;
    logic [NSEG-1:0]    c;
    logic [WIDTH-1:0]   w [NSEG];
    logic [(BP_W > 0 ? BP_W : 1)-1:0] bp;
    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;

`ifdef PIPE_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // A stage can take new data if it is empty or its successor is moving.
    always_comb begin
        rdy       = '0;
        rdy[NSEG] = out_ready;
        for (int k = NSEG - 1; k >= 0; k--) begin
            rdy[k] = !v[k] || rdy[k+1];
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int BW       = WIDTH - k * SEG_W;
        localparam int BOFF_IN  = tri_off(WIDTH, SEG_W, k);
        localparam int BOFF_OUT = tri_off(WIDTH, SEG_W, k + 1);

        logic             up_v;
        logic             c_up;
        logic             ld;
        logic [WIDTH-1:0] w_in;
        logic [BW-1:0]    b_in;
        logic [SEG_W-1:0] s_seg;

        if (k == 0) begin : g_first
            assign up_v = in_valid;
            assign c_up = cin_eff;
            assign w_in = a;
            assign b_in = b_eff;
        end else begin : g_next
            assign up_v = v[k-1];
            assign c_up = c[k-1];
            assign w_in = w[k-1];
            assign b_in = bp[BOFF_IN +: BW];
        end

        assign ld = rdy[k] && up_v;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v[k] <= 1'b0;
            end else if (rdy[k]) begin
                v[k] <= up_v;
            end
        end

        adder_seg_stage #(.SEG_W(SEG_W)) u_seg (
            .clk   (clk),
            .rst_n (rst_n),
            .ld    (ld),
            .a_seg (w_in[SEG_W-1:0]),
            .b_seg (b_in[SEG_W-1:0]),
            .c_in  (c_up),
            .s_seg (s_seg),
            .c_out (c[k])
        );

        // Finished segments enter at the top and rotate down past the pending a bits.
        if (NSEG > 1) begin : g_rest
            logic [WIDTH-SEG_W-1:0] rest;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rest <= '0;
                end else if (ld) begin
                    rest <= w_in[WIDTH-1:SEG_W];
                end
            end
            assign w[k] = {s_seg, rest};
        end else begin : g_norest
            assign w[k] = s_seg;
        end

        if (k < NSEG - 1) begin : g_bp
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bp[BOFF_OUT +: BW-SEG_W] <= '0;
                end else if (ld) begin
                    bp[BOFF_OUT +: BW-SEG_W] <= b_in[BW-1:SEG_W];
                end
            end
        end
    end

    if (BP_W == 0) begin : g_no_bp
        assign bp = 1'b0;
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[NSEG-1];
    assign sum       = w[NSEG-1];
    assign cout      = c[NSEG-1];

endmodule
